// File: rtl/regmode_cfg_pkg.sv
// Shared types for the register-mode tile configuration controller:
// address field decode, controller FSM states and the tile mode width.
package regmode_cfg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    FIELD_MODE  = 2'd0,
    FIELD_CONST = 2'd1,
    FIELD_VALUE = 2'd2,
    FIELD_RSVD  = 2'd3
  } field_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_APPLY   = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/regmode_cfg_regfile.sv
// Per-tile mode/const storage with a single write port and a combinational
// read port; the flattened buses drive the tiles directly.
module regmode_cfg_regfile
  import regmode_cfg_pkg::*;
#(
  parameter int                NUM_REGS   = 4,
  parameter int                WIDTH      = 4,
  parameter logic [MODE_W-1:0] RESET_MODE = 2'd2,
  parameter int                SLOT_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_mode,
  input  logic                       we_const,
  input  logic [SLOT_W-1:0]          wr_slot,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [SLOT_W-1:0]          rd_slot,
  output logic [MODE_W-1:0]          rd_mode,
  output logic [WIDTH-1:0]           rd_const,
  output logic [NUM_REGS*MODE_W-1:0] mode,
  output logic [NUM_REGS*WIDTH-1:0]  const_
);

  logic [MODE_W-1:0] mode_q  [NUM_REGS];
  logic [WIDTH-1:0]  const_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mode_q[i]  <= RESET_MODE;
        const_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_mode && (wr_slot == SLOT_W'(i)))  mode_q[i]  <= wdata[MODE_W-1:0];
        if (we_const && (wr_slot == SLOT_W'(i))) const_q[i] <= wdata;
      end
    end
  end

  // Out-of-range slots read as zero; the controller flags them as errors anyway.
  always_comb begin
    rd_mode  = '0;
    rd_const = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_slot == SLOT_W'(i)) begin
        rd_mode  = mode_q[i];
        rd_const = const_q[i];
      end
    end
  end

  always_comb begin
    mode   = '0;
    const_ = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      mode[i*MODE_W +: MODE_W] = mode_q[i];
      const_[i*WIDTH +: WIDTH] = const_q[i];
    end
  end

endmodule

// File: rtl/regmode_cfg_ctrl.sv
// Configuration controller for a bank of register-mode tiles: one request at a
// time, tile clock gated off for the two cycles around every legal write.
module regmode_cfg_ctrl
  import regmode_cfg_pkg::*;
#(
  parameter int                NUM_REGS   = 4,
  parameter int                WIDTH      = 4,
  parameter logic [MODE_W-1:0] RESET_MODE = 2'd2,
  localparam int               SLOT_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESETN,
  // Handshakes: a beat transfers on the rising edge where valid & ready are both
  // high; valid and its payload stay stable until then, ready never waits on valid.
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_write,
  input  logic [SLOT_W+1:0]          cfg_addr,
  input  logic [WIDTH-1:0]           cfg_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_rdata,
  output logic                       resp_err,
  input  logic                       user_clk_en,
  input  logic [NUM_REGS*WIDTH-1:0]  reg_value,
  output logic [NUM_REGS*MODE_W-1:0] mode,
  output logic [NUM_REGS*WIDTH-1:0]  const_,
  output logic [NUM_REGS-1:0]        config_we,
  output logic [WIDTH-1:0]           config_data,
  output logic                       clk_en,
  output logic [1:0]                 dbg_state
);

  localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W+1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] req_slot, slot_q;
  field_t            req_field, field_q;
  logic [WIDTH-1:0]  wdata_q, rdata_q, cfg_data_q;
  logic [WIDTH-1:0]  value_rd, rd_src, rd_const;
  logic [MODE_W-1:0] rd_mode;
  logic              err_q, accept, req_legal, apply;

  assign req_slot  = cfg_addr[SLOT_W+1:2];
  assign req_field = field_t'(cfg_addr[1:0]);
  assign accept    = cfg_valid && (state_q == ST_IDLE);
  assign req_legal = ({1'b0, req_slot} < SLOT_LIMIT) && (req_field != FIELD_RSVD);
  assign apply     = (state_q == ST_APPLY);

  always_comb begin
    value_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_slot == SLOT_W'(i)) value_rd = reg_value[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_src = '0;
    case (req_field)
      FIELD_MODE:  rd_src = WIDTH'(rd_mode);
      FIELD_CONST: rd_src = rd_const;
      FIELD_VALUE: rd_src = value_rd;
      default:     rd_src = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (cfg_write && req_legal) ? ST_QUIESCE : ST_RESP;
      end
      ST_QUIESCE: state_d = ST_APPLY;
      ST_APPLY:   state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Response is captured at accept so reg_value readback reflects that edge.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      slot_q     <= '0;
      field_q    <= FIELD_MODE;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cfg_data_q <= '0;
    end else begin
      if (accept) begin
        slot_q  <= req_slot;
        field_q <= req_field;
        wdata_q <= cfg_wdata;
        err_q   <= !req_legal;
        rdata_q <= (!cfg_write && req_legal) ? rd_src : '0;
      end
      if (state_q == ST_QUIESCE) cfg_data_q <= wdata_q;
    end
  end

  // Decoded from state so an asynchronous reset drops the strobe immediately.
  always_comb begin
    config_we = '0;
    if (apply && (field_q == FIELD_VALUE)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (slot_q == SLOT_W'(i)) config_we[i] = 1'b1;
      end
    end
  end

  regmode_cfg_regfile #(
    .NUM_REGS  (NUM_REGS),
    .WIDTH     (WIDTH),
    .RESET_MODE(RESET_MODE),
    .SLOT_W    (SLOT_W)
  ) u_regfile (
    .clk     (CLK),
    .rst_n   (ASYNCRESETN),
    .we_mode (apply && (field_q == FIELD_MODE)),
    .we_const(apply && (field_q == FIELD_CONST)),
    .wr_slot (slot_q),
    .wdata   (wdata_q),
    .rd_slot (req_slot),
    .rd_mode (rd_mode),
    .rd_const(rd_const),
    .mode    (mode),
    .const_  (const_)
  );

  assign cfg_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign config_data = cfg_data_q;
  assign clk_en      = user_clk_en && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_regmode_cfg_ctrl.sv
// Bench for regmode_cfg_ctrl: directed scenarios plus a randomized run against
// a transaction-level model of the tile bank; a 3-tile instance covers bad slots.
module tb_regmode_cfg_ctrl;

  localparam int N = 4;
  localparam int W = 4;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN = 1'b1;
  logic          cfg_valid, cfg_write, resp_ready, user_clk_en;
  logic [3:0]    cfg_addr, cfg_wdata;
  logic [15:0]   reg_value;
  logic          cfg_ready, resp_valid, resp_err, clk_en;
  logic [3:0]    resp_rdata, config_we, config_data;
  logic [7:0]    mode;
  logic [15:0]   const_;
  logic [1:0]    dbg_state;

  logic          d3_cfg_valid, d3_cfg_write, d3_resp_ready, d3_user_clk_en;
  logic [3:0]    d3_cfg_addr, d3_cfg_wdata;
  logic [11:0]   d3_reg_value;
  logic          d3_cfg_ready, d3_resp_valid, d3_resp_err, d3_clk_en;
  logic [3:0]    d3_resp_rdata, d3_config_data;
  logic [2:0]    d3_config_we;
  logic [5:0]    d3_mode;
  logic [11:0]   d3_const;
  logic [1:0]    d3_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]    m_mode  [N];
  logic [3:0]    m_const [N];
  logic [W-1:0]  exp_q[$];

  regmode_cfg_ctrl #(.NUM_REGS(4), .WIDTH(4), .RESET_MODE(2'd2)) u_dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .user_clk_en(user_clk_en), .reg_value(reg_value),
    .mode(mode), .const_(const_), .config_we(config_we), .config_data(config_data),
    .clk_en(clk_en), .dbg_state(dbg_state)
  );

  regmode_cfg_ctrl #(.NUM_REGS(3), .WIDTH(4), .RESET_MODE(2'd2)) u_dut3 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .cfg_valid(d3_cfg_valid), .cfg_ready(d3_cfg_ready), .cfg_write(d3_cfg_write),
    .cfg_addr(d3_cfg_addr), .cfg_wdata(d3_cfg_wdata),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready), .resp_rdata(d3_resp_rdata),
    .resp_err(d3_resp_err), .user_clk_en(d3_user_clk_en), .reg_value(d3_reg_value),
    .mode(d3_mode), .const_(d3_const), .config_we(d3_config_we),
    .config_data(d3_config_data), .clk_en(d3_clk_en), .dbg_state(d3_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i]  = 2'd2;
      m_const[i] = 4'd0;
    end
  endtask

  function automatic logic [7:0] exp_mode_vec();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i*2 +: 2] = m_mode[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_const_vec();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[i*4 +: 4] = m_const[i];
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, then observes the cycles until the response appears,
  // holds resp_ready low for 'hold' cycles and completes the handshake.
  task automatic run_txn(input logic wr, input int slot, input int field,
                         input logic [3:0] wd, input int hold,
                         output int lat, output int en_low, output int we_cycles,
                         output logic [3:0] we_val, output logic [3:0] we_data,
                         output logic [3:0] rd, output logic er,
                         output int unstable, output logic post_ok);
    lat = -1; en_low = 0; we_cycles = 0; we_val = '0; we_data = '0;
    rd = '0; er = 1'b0; unstable = 0; post_ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_write = wr;
    cfg_addr  = {slot[1:0], field[1:0]};
    cfg_wdata = wd;
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (user_clk_en && !clk_en) en_low++;
      if (config_we != '0) begin
        we_cycles++;
        we_val  = config_we;
        we_data = config_data;
      end
      @(posedge CLK); #1;
    end
    if (lat > 0) begin
      rd = resp_rdata;
      er = resp_err;
      repeat (hold) begin
        @(posedge CLK); #1;
        if (resp_rdata !== rd || resp_err !== er || resp_valid !== 1'b1 || cfg_ready !== 1'b0)
          unstable++;
      end
      resp_ready = 1'b1;
      @(posedge CLK); #1;
      resp_ready = 1'b0;
      post_ok = (resp_valid === 1'b0) && (cfg_ready === 1'b1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 ASYNCRESETN = 1'b0;
    #1;
    n_cmp++; if (mode !== 8'hAA) begin n_bad++; $display("FAIL reset_mode: got %h want aa", mode); end
    n_cmp++; if (const_ !== 16'h0) begin n_bad++; $display("FAIL reset_const: got %h want 0000", const_); end
    n_cmp++; if ({config_we, config_data} !== 8'h00) begin n_bad++; $display("FAIL reset_config: got we=%b data=%h want 0", config_we, config_data); end
    n_cmp++; if ({resp_valid, resp_err, resp_rdata} !== 6'd0) begin n_bad++; $display("FAIL reset_resp: got v=%b e=%b d=%h want 0", resp_valid, resp_err, resp_rdata); end
    repeat (2) @(posedge CLK);
    @(negedge CLK) ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    n_cmp++; if (clk_en !== 1'b1) begin n_bad++; $display("FAIL reset_clk_en: got %b want 1", clk_en); end
  endtask

  task automatic test_clk_en_idle();
    for (int k = 0; k < 6; k++) begin
      user_clk_en = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (clk_en !== user_clk_en) begin n_bad++; $display("FAIL idle_clk_en: got %b want %b", clk_en, user_clk_en); end
      @(posedge CLK); #1;
    end
    user_clk_en = 1'b1;
  endtask

  task automatic test_const_write();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    run_txn(1'b1, 1, 1, 4'hA, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    m_const[1] = 4'hA;
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL const_latency: got %0d want 3", lat); end
    n_cmp++; if (en_low !== 2) begin n_bad++; $display("FAIL const_clk_en_low: got %0d want 2", en_low); end
    n_cmp++; if ({er, rd} !== 5'd0) begin n_bad++; $display("FAIL const_resp: got e=%b d=%h want 0", er, rd); end
    n_cmp++; if (wec !== 0) begin n_bad++; $display("FAIL const_no_we: got %0d want 0", wec); end
    n_cmp++; if (const_ !== exp_const_vec()) begin n_bad++; $display("FAIL const_value: got %h want %h", const_, exp_const_vec()); end
    n_cmp++; if (mode !== exp_mode_vec()) begin n_bad++; $display("FAIL const_mode_kept: got %h want %h", mode, exp_mode_vec()); end
  endtask

  task automatic test_value_write();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    reg_value = 16'($urandom);
    run_txn(1'b1, 3, 2, 4'h5, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    n_cmp++; if (wec !== 1) begin n_bad++; $display("FAIL value_we_cycles: got %0d want 1", wec); end
    n_cmp++; if ({wv, wdat} !== {4'b1000, 4'h5}) begin n_bad++; $display("FAIL value_we_pulse: got we=%b data=%h want 1000/5", wv, wdat); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL value_latency: got %0d want 3", lat); end
    n_cmp++; if (config_we !== 4'b0000) begin n_bad++; $display("FAIL value_we_idle: got %b want 0000", config_we); end
    reg_value = {4'h5, 12'($urandom)};
    run_txn(1'b0, 3, 2, 4'h0, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    n_cmp++; if ({lat, er, rd} !== {32'd1, 1'b0, 4'h5}) begin n_bad++; $display("FAIL value_readback: got lat=%0d e=%b d=%h want 1/0/5", lat, er, rd); end
  endtask

  task automatic test_mode_read_hold();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    run_txn(1'b1, 0, 0, 4'hD, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    m_mode[0] = 2'b01;
    n_cmp++; if (mode !== exp_mode_vec()) begin n_bad++; $display("FAIL mode_write: got %h want %h", mode, exp_mode_vec()); end
    run_txn(1'b0, 0, 0, 4'hF, 5, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    n_cmp++; if ({lat, er, rd} !== {32'd1, 1'b0, 4'h1}) begin n_bad++; $display("FAIL mode_read: got lat=%0d e=%b d=%h want 1/0/1", lat, er, rd); end
    n_cmp++; if (uns !== 0) begin n_bad++; $display("FAIL mode_hold_stable: got %0d unstable cycles want 0", uns); end
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL mode_hold_release: got %b want 1", pok); end
  endtask

  task automatic test_errors();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    run_txn(1'b1, 2, 3, 4'hF, 1, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    n_cmp++; if ({lat, er, rd} !== {32'd1, 1'b1, 4'h0}) begin n_bad++; $display("FAIL err_write_resp: got lat=%0d e=%b d=%h want 1/1/0", lat, er, rd); end
    n_cmp++; if ({en_low, wec} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL err_write_effects: got en_low=%0d we=%0d want 0/0", en_low, wec); end
    n_cmp++; if ({mode, const_} !== {exp_mode_vec(), exp_const_vec()}) begin n_bad++; $display("FAIL err_write_state: got %h/%h want %h/%h", mode, const_, exp_mode_vec(), exp_const_vec()); end
    run_txn(1'b0, 1, 3, 4'h0, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    n_cmp++; if ({lat, er, rd} !== {32'd1, 1'b1, 4'h0}) begin n_bad++; $display("FAIL err_read_resp: got lat=%0d e=%b d=%h want 1/1/0", lat, er, rd); end
  endtask

  task automatic test_back_to_back();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    run_txn(1'b1, 2, 1, 4'h3, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    m_const[2] = 4'h3;
    n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after: got %b want 1", pok); end
    run_txn(1'b1, 2, 0, 4'h2, 0, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
    m_mode[2] = 2'd2;
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 3", lat); end
    n_cmp++; if ({mode, const_} !== {exp_mode_vec(), exp_const_vec()}) begin n_bad++; $display("FAIL b2b_state: got %h/%h want %h/%h", mode, const_, exp_mode_vec(), exp_const_vec()); end
  endtask

  task automatic test_random();
    int lat, en_low, wec, uns; logic [3:0] wv, wdat, rd; logic er, pok;
    logic wr; int slot, field, hold, exp_lat, exp_en; logic [3:0] wd, exp_rd; logic legal;
    for (int k = 0; k < 60; k++) begin
      wr = 1'($urandom_range(0, 1)); slot = $urandom_range(0, 3); field = $urandom_range(0, 3);
      wd = 4'($urandom); hold = $urandom_range(0, 2); reg_value = 16'($urandom);
      legal   = (field != 3);
      exp_lat = (wr && legal) ? 3 : 1;
      exp_en  = (wr && legal) ? 2 : 0;
      exp_rd  = 4'h0;
      if (!wr && legal) begin
        if (field == 0)      exp_rd = {2'b00, m_mode[slot]};
        else if (field == 1) exp_rd = m_const[slot];
        else                 exp_rd = reg_value[slot*4 +: 4];
      end
      exp_q.push_back(exp_rd);
      run_txn(wr, slot, field, wd, hold, lat, en_low, wec, wv, wdat, rd, er, uns, pok);
      if (wr && legal && field == 0) m_mode[slot]  = wd[1:0];
      if (wr && legal && field == 1) m_const[slot] = wd;
      exp_rd = exp_q.pop_front();
      n_cmp++; if ({lat, er, rd} !== {exp_lat, !legal, exp_rd}) begin n_bad++; $display("FAIL rnd_resp[%0d]: got lat=%0d e=%b d=%h want %0d/%b/%h", k, lat, er, rd, exp_lat, !legal, exp_rd); end
      n_cmp++; if ({en_low, uns} !== {exp_en, 32'd0}) begin n_bad++; $display("FAIL rnd_gate[%0d]: got en_low=%0d unstable=%0d want %0d/0", k, en_low, uns, exp_en); end
      n_cmp++; if (pok !== 1'b1) begin n_bad++; $display("FAIL rnd_release[%0d]: got %b want 1", k, pok); end
      if (wr && legal && field == 2) begin
        n_cmp++; if ({wec, wv, wdat} !== {32'd1, 4'(1 << slot), wd}) begin n_bad++; $display("FAIL rnd_we[%0d]: got n=%0d we=%b d=%h want 1/%b/%h", k, wec, wv, wdat, 4'(1 << slot), wd); end
      end else begin
        n_cmp++; if (wec !== 0) begin n_bad++; $display("FAIL rnd_no_we[%0d]: got %0d want 0", k, wec); end
      end
      n_cmp++; if ({mode, const_} !== {exp_mode_vec(), exp_const_vec()}) begin n_bad++; $display("FAIL rnd_state[%0d]: got %h/%h want %h/%h", k, mode, const_, exp_mode_vec(), exp_const_vec()); end
    end
  endtask

  task automatic test_bad_slot();
    d3_user_clk_en = 1'b1; d3_reg_value = 12'hFFF;
    d3_cfg_valid = 1'b1; d3_cfg_write = 1'b0; d3_cfg_addr = {2'd3, 2'd0};
    @(posedge CLK); #1; d3_cfg_valid = 1'b0;
    n_cmp++; if ({d3_resp_valid, d3_resp_err, d3_resp_rdata} !== {1'b1, 1'b1, 4'h0}) begin n_bad++; $display("FAIL slot3_read: got v=%b e=%b d=%h want 1/1/0", d3_resp_valid, d3_resp_err, d3_resp_rdata); end
    d3_resp_ready = 1'b1; @(posedge CLK); #1; d3_resp_ready = 1'b0;
    d3_cfg_valid = 1'b1; d3_cfg_write = 1'b1; d3_cfg_addr = {2'd3, 2'd1}; d3_cfg_wdata = 4'hF;
    @(posedge CLK); #1; d3_cfg_valid = 1'b0;
    n_cmp++; if ({d3_resp_valid, d3_resp_err, d3_resp_rdata, d3_clk_en} !== {1'b1, 1'b1, 4'h0, 1'b1}) begin n_bad++; $display("FAIL slot3_write: got v=%b e=%b d=%h en=%b want 1/1/0/1", d3_resp_valid, d3_resp_err, d3_resp_rdata, d3_clk_en); end
    n_cmp++; if ({d3_mode, d3_const, d3_config_we} !== {6'b101010, 12'h000, 3'b000}) begin n_bad++; $display("FAIL slot3_no_effect: got %h/%h/%b want 2a/000/000", d3_mode, d3_const, d3_config_we); end
    d3_resp_ready = 1'b1; @(posedge CLK); #1; d3_resp_ready = 1'b0;
    d3_cfg_valid = 1'b1; d3_cfg_write = 1'b0; d3_cfg_addr = {2'd2, 2'd2}; d3_reg_value = 12'h7FF;
    @(posedge CLK); #1; d3_cfg_valid = 1'b0;
    n_cmp++; if ({d3_resp_err, d3_resp_rdata} !== {1'b0, 4'h7}) begin n_bad++; $display("FAIL slot2_read: got e=%b d=%h want 0/7", d3_resp_err, d3_resp_rdata); end
    d3_resp_ready = 1'b1; @(posedge CLK); #1; d3_resp_ready = 1'b0;
    n_cmp++; if (d3_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL slot3_ready: got %b want 1", d3_cfg_ready); end
  endtask

  task automatic test_reset_apply();
    reg_value = 16'($urandom);
    cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = {2'd2, 2'd2}; cfg_wdata = 4'h9;
    @(posedge CLK); #1; cfg_valid = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if ({config_we, config_data, clk_en} !== {4'b0100, 4'h9, 1'b0}) begin n_bad++; $display("FAIL rst_apply_pre: got we=%b d=%h en=%b want 0100/9/0", config_we, config_data, clk_en); end
    #2 ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({config_we, config_data, resp_valid, clk_en} !== {4'b0000, 4'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL rst_apply_async: got we=%b d=%h v=%b en=%b want 0000/0/0/1", config_we, config_data, resp_valid, clk_en); end
    n_cmp++; if ({mode, const_} !== {exp_mode_vec(), exp_const_vec()}) begin n_bad++; $display("FAIL rst_apply_state: got %h/%h want %h/%h", mode, const_, exp_mode_vec(), exp_const_vec()); end
    #4 ASYNCRESETN = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if ({cfg_ready, resp_valid, config_we} !== {1'b1, 1'b0, 4'b0000}) begin n_bad++; $display("FAIL rst_apply_release: got r=%b v=%b we=%b want 1/0/0000", cfg_ready, resp_valid, config_we); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    resp_ready = 1'b0; user_clk_en = 1'b1; reg_value = '0;
    d3_cfg_valid = 1'b0; d3_cfg_write = 1'b0; d3_cfg_addr = '0; d3_cfg_wdata = '0;
    d3_resp_ready = 1'b0; d3_user_clk_en = 1'b1; d3_reg_value = '0;
    model_reset();
    test_reset();
    test_clk_en_idle();
    test_const_write();
    test_value_write();
    test_mode_read_hold();
    test_errors();
    test_back_to_back();
    test_random();
    test_bad_slot();
    test_reset_apply();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
